// File: rtl/v1_lsu.sv
// v1_lsu: data-side load/store responder for the Eka v1 core (IDLE -> REQ -> DONE).
// Optional bus-ack timeout is compiled in with `define LSU_TIMEOUT_EN.
module v1_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_err;

  logic        w_req;
  logic        w_store;
  logic        w_legal_f3;
  logic        w_misal;
  logic        w_bad;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  // Request decode: legality, alignment, byte enables and lane-replicated store data
  always_comb begin
    w_req      = mem_rd | mem_wr;
    w_store    = mem_wr;
    w_legal_f3 = 1'b0;
    w_misal    = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = wdata;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
      3'b100, 3'b101:         w_legal_f3 = ~w_store;
      default:                w_legal_f3 = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        w_misal = 1'b0;
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_misal = addr[0];
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_misal = (addr[1:0] != 2'b00);
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
    w_bad = w_req & (~w_legal_f3 | w_misal);
    w_go  = w_req & ~w_bad;
  end

  // Load extraction from the returned word using the latched offset and size
  always_comb begin
    w_byte = bus_rdata[7:0];
    w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_addr_lo)
      2'b00:   w_byte = bus_rdata[7:0];
      2'b01:   w_byte = bus_rdata[15:8];
      2'b10:   w_byte = bus_rdata[23:16];
      2'b11:   w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  // Stall and error must react in the request cycle itself, so they are partly combinational
  always_comb begin
    stall      = (r_state == S_REQ) | ((r_state == S_IDLE) & w_go);
    access_err = ((r_state == S_IDLE) & w_bad) | r_err;
  end

  // Transaction FSM with registered bus outputs and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_err     <= 1'b0;
      rdata     <= 32'h0000_0000;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (w_go) begin
            r_state   <= S_REQ;
            r_funct3  <= funct3;
            r_addr_lo <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= w_store;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata   <= bus_we ? 32'h0000_0000 : w_load;
            r_state <= S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            bus_req <= 1'b0;
            rdata   <= 32'h0000_0000;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`else
          else begin
            r_state <= S_REQ;
          end
`endif
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v1_lsu.sv
// Directed self-checking bench for v1_lsu; timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_v1_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int tests = 0;
  int fails = 0;

  int          stall_cnt;
  logic        c_req, c_we, c_done_stall, c_done_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;

  v1_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .access_err(access_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; ack arrives after dly empty REQ cycles.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] brd, input int dly);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    stall_cnt = 0;
    @(negedge clk); if (stall) stall_cnt++;
    @(posedge clk); #1; mem_rd = 1'b0; mem_wr = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk); if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b1; bus_rdata = brd;
    @(negedge clk); if (stall) stall_cnt++;
    c_req = bus_req; c_we = bus_we; c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata;
    @(posedge clk); #1; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); if (stall) stall_cnt++;
    c_rdata = rdata; c_done_stall = stall; c_done_err = access_err;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_err", {31'h0, access_err}, 32'h0);
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_we", {31'h0, bus_we}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", {28'h0, bus_be}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // LW 0x100, ack in first REQ cycle
    access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_req", {31'h0, c_req}, 32'h1);
    chk("lw_we", {31'h0, c_we}, 32'h0);
    chk("lw_addr", c_addr, 32'h0000_0100);
    chk("lw_be", {28'h0, c_be}, 32'hF);
    chk("lw_stall_cycles", stall_cnt, 32'd2);
    chk("lw_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("lw_done_stall", {31'h0, c_done_stall}, 32'h0);
    chk("lw_done_err", {31'h0, c_done_err}, 32'h0);

    // LB / LBU on byte 3
    access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0);
    chk("lb_addr", c_addr, 32'h0000_0200);
    chk("lb_be", {28'h0, c_be}, 32'h8);
    chk("lb_rdata", c_rdata, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0);
    chk("lbu_rdata", c_rdata, 32'h0000_0080);

    // LH / LHU on upper half
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7F7F, 0);
    chk("lh_be", {28'h0, c_be}, 32'hC);
    chk("lh_rdata", c_rdata, 32'hFFFF_8001);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_7F7F, 0);
    chk("lhu_rdata", c_rdata, 32'h0000_8001);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h0000_7FFE, 0);
    chk("lh_lo_rdata", c_rdata, 32'h0000_7FFE);

    // SH 0x42
    access(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
    chk("sh_we", {31'h0, c_we}, 32'h1);
    chk("sh_addr", c_addr, 32'h0000_0040);
    chk("sh_be", {28'h0, c_be}, 32'hC);
    chk("sh_wdata", c_wdata, 32'hABCD_ABCD);
    chk("sh_rdata", c_rdata, 32'h0);

    // SB with both rd and wr set is a store; ack after 3 wait cycles
    access(1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'hCAFE_0077, 32'h1111_1111, 3);
    chk("sb_we", {31'h0, c_we}, 32'h1);
    chk("sb_be", {28'h0, c_be}, 32'h2);
    chk("sb_wdata", c_wdata, 32'h7777_7777);
    chk("sb_stall_cycles", stall_cnt, 32'd5);
    chk("sb_rdata", c_rdata, 32'h0);

    // Illegal and misaligned accesses: same-cycle error, no stall, no bus
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0101;
    @(negedge clk);
    chk("mis_lw_err", {31'h0, access_err}, 32'h1);
    chk("mis_lw_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    funct3 = 3'b011; addr = 32'h0000_0100;
    @(negedge clk);
    chk("f3_011_err", {31'h0, access_err}, 32'h1);
    chk("f3_011_req", {31'h0, bus_req}, 32'h0);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b1; funct3 = 3'b100; addr = 32'h0000_0100;
    @(negedge clk);
    chk("st_f3_100_err", {31'h0, access_err}, 32'h1);
    @(posedge clk); #1;
    mem_wr = 1'b1; funct3 = 3'b001; addr = 32'h0000_0103;
    @(negedge clk);
    chk("mis_sh_err", {31'h0, access_err}, 32'h1);
    @(posedge clk); #1;
    mem_wr = 1'b0;
    @(negedge clk);
    chk("ill_after_req", {31'h0, bus_req}, 32'h0);
    chk("ill_after_err", {31'h0, access_err}, 32'h0);
    @(posedge clk); #1;

    // Reset on third REQ cycle, then a stray late ack
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    @(posedge clk); #1; mem_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(negedge clk);
    chk("rst3_req_before", {31'h0, bus_req}, 32'h1);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst3_req_after", {31'h0, bus_req}, 32'h0);
    chk("rst3_stall_after", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_req", {31'h0, bus_req}, 32'h0);
    chk("late_ack_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, 1);
    chk("recover_rdata", c_rdata, 32'h0BAD_F00D);
    chk("recover_stall_cycles", stall_cnt, 32'd3);

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      n = 0;
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
      @(posedge clk); #1; mem_rd = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus_req) break;
        n++;
        @(posedge clk); #1;
      end
      chk("to_req_cycles", n, 32'd4);
      chk("to_err", {31'h0, access_err}, 32'h1);
      chk("to_rdata", rdata, 32'h0);
      chk("to_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_err_clear", {31'h0, access_err}, 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/v1_lsu.md
Name: v1_lsu

Overview:
- Load/store responder on the data side of the Eka v1 core; it acts on the mem_rd/mem_wr/funct3 controls generated by the decoder.
- Accepts one core access at a time and stalls the core while the access is outstanding.
- Converts the access into a word-aligned req/ack transaction with byte enables on the data bus.
- Returns sign- or zero-extended load data and flags misaligned or illegal accesses.

Parameters:
- TIMEOUT_CYCLES, 255: max REQ cycles without bus_ack before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_rd  in  1  load request from decoder
- mem_wr  in  1  store request from decoder
- funct3  in  3  instruction[14:12]; access size/sign
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data, valid in DONE
- stall  out  1  core must hold PC and inputs while high
- access_err  out  1  one-cycle error pulse
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_ack  in  1  one-cycle completion
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; all registered outputs 0 (rdata, access_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata); stall=0.
- FSM states: IDLE, REQ, DONE.
- IDLE, no request (mem_rd=mem_wr=0): stall=0; remain in IDLE.
- IDLE, request present: stall=1 combinationally in the same cycle.
  - Latch addr, funct3, bus_we=mem_wr, bus_be and bus_wdata.
  - Go to REQ.
  - If mem_rd and mem_wr are both set, treat the access as a store.
- Access legality:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - On an illegal or misaligned access in IDLE: no bus transaction, stall=0, access_err=1 combinationally for that cycle, stay in IDLE.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: bus_wdata = wdata replicated into the enabled lanes (byte: {4{wdata[7:0]}}; half: {2{wdata[15:0]}}).
- REQ: bus_req=1 with bus_we/addr/be/wdata held stable; stall=1.
  - On bus_ack: capture the extended load into rdata (stores: rdata=0) and go to DONE.
  - No bus_ack: stay in REQ.
- Load extraction: select the byte/half indexed by the latched addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- DONE: stall=0 and rdata valid; the core retires the instruction this cycle. Next state is IDLE unconditionally, so the next request is seen one cycle later.
- Latency: ack in the first REQ cycle gives 3 cycles from request to retire, with stall high for 2. Each extra wait cycle adds 1.
- bus_ack outside REQ is ignored.
- Reset mid-transaction: next edge forces IDLE and bus_req=0; any late ack is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: drop bus_req, go to DONE with rdata=0 and access_err=1 for the DONE cycle.
- Undefined: no counter; REQ waits indefinitely for bus_ack.

Test Plan:
- LW addr=0x100, ack on first REQ cycle, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- LB addr=0x203, bus_rdata=0x80FF_0000; then LBU same -> rdata=0xFFFFFF80, then 0x00000080.
- SH addr=0x42, wdata=0x1234ABCD -> bus_we=1, bus_addr=0x40, bus_be=1100, bus_wdata=0xABCDABCD, rdata=0.
- LW addr=0x101 and funct3=011 -> access_err=1 same cycle, stall=0, bus_req never asserted.
- LW with ack delayed 5 cycles, reset asserted on the 3rd REQ cycle -> next cycle IDLE, bus_req=0, later ack has no effect.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then DONE with access_err=1, rdata=0, stall=0.
